// File: rtl/ca_rx_align_pkg.sv
// Shared types and constants for the RX channel-alignment controller.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package ca_rx_align_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    ALIGNED,
    ERR
  } ca_align_st_t;

  localparam int SKIP_CNT_W = 8;

  // Saturating increment for the discarded-word counter.
  function automatic logic [SKIP_CNT_W-1:0] skip_sat_inc(input logic [SKIP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ca_rx_align_lane.sv
// Per-channel head inspection: marker extraction, hunt discard request, head presence.
// Latency: purely combinational, zero cycles.
// Backpressure: a lane whose head carries the marker holds it (no hunt pop).
module ca_rx_align_lane #(
  parameter int BITS_PER_CHANNEL = 80,
  parameter int MARKER_LOC       = 76
) (
  input  logic                        rd_empty,
  input  logic [BITS_PER_CHANNEL-1:0] dout,
  output logic                        mk,
  output logic                        hunt_pop,
  output logic                        lane_rdy,
  output logic [BITS_PER_CHANNEL-1:0] head_dat
);

  // Marker bit of the show-ahead head word; pre-marker heads are discarded while hunting.
  always_comb begin
    mk       = dout[MARKER_LOC];
    lane_rdy = !rd_empty;
    hunt_pop = !rd_empty && !dout[MARKER_LOC];
    head_dat = dout;
  end

endmodule

// File: rtl/ca_rx_align_ctrl.sv
// Deskews RX channel FIFOs on the marker bit, then pops all channels in lockstep into one registered wide word.
// Latency: fifo_pop combinational; rx_data/rx_data_vld one cycle after the pop.
// Backpressure: any empty channel stalls the whole aligned pop; optional post-lock marker check via CA_RX_ALIGN_MARKER_CHECK_EN.
module ca_rx_align_ctrl
  import ca_rx_align_pkg::*;
#(
  parameter int NUM_CHANNELS     = 2,
  parameter int BITS_PER_CHANNEL = 80,
  parameter int MARKER_LOC       = 76,
  parameter int TIMEOUT_W        = 8
) (
  input  logic                                      com_clk,
  input  logic                                      rst_com,
  input  logic                                      align_en,
  input  logic [NUM_CHANNELS-1:0]                   rd_empty,
  input  logic [NUM_CHANNELS*BITS_PER_CHANNEL-1:0]  rx_dout,
  output logic [NUM_CHANNELS-1:0]                   fifo_pop,
  output logic [NUM_CHANNELS*BITS_PER_CHANNEL-1:0]  rx_data,
  output logic                                      rx_data_vld,
  output logic                                      align_done,
  output logic                                      align_err,
  output logic [SKIP_CNT_W-1:0]                     skip_cnt
);

  localparam int DW = NUM_CHANNELS * BITS_PER_CHANNEL;
  // Last hunt cycle: the counter holds 2^TIMEOUT_W-2 during the (2^TIMEOUT_W-1)th HUNT cycle.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  ca_align_st_t           st;
  ca_align_st_t           nxt;
  logic [NUM_CHANNELS-1:0] mk;
  logic [NUM_CHANNELS-1:0] hunt_pop;
  logic [NUM_CHANNELS-1:0] lane_rdy;
  logic [DW-1:0]          head_dat;
  logic                   all_rdy;
  logic                   lock_ok;
  logic                   pop_all;
  logic [TIMEOUT_W-1:0]   tmo_cnt;

  for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_lane
    ca_rx_align_lane #(
      .BITS_PER_CHANNEL (BITS_PER_CHANNEL),
      .MARKER_LOC       (MARKER_LOC)
    ) u_lane (
      .rd_empty (rd_empty[n]),
      .dout     (rx_dout[n*BITS_PER_CHANNEL +: BITS_PER_CHANNEL]),
      .mk       (mk[n]),
      .hunt_pop (hunt_pop[n]),
      .lane_rdy (lane_rdy[n]),
      .head_dat (head_dat[n*BITS_PER_CHANNEL +: BITS_PER_CHANNEL])
    );
  end

`ifdef CA_RX_ALIGN_MARKER_CHECK_EN
  logic mk_mismatch;

  // After lock every popped word must carry the same marker value as channel 0.
  always_comb begin
    mk_mismatch = |(mk ^ {NUM_CHANNELS{mk[0]}});
  end
`endif

  // Lock when every channel has a head and every head carries the marker.
  always_comb begin
    all_rdy = &lane_rdy;
    lock_ok = all_rdy && (&mk);
  end

  // State register.
  always_ff @(posedge com_clk) begin
    if (rst_com) begin
      st <= IDLE;
    end else begin
      st <= nxt;
    end
  end

  // Next state and pops; align_en low overrides everything in the same cycle.
  always_comb begin
    nxt      = st;
    fifo_pop = '0;
    pop_all  = 1'b0;
    case (st)
      IDLE: begin
        if (align_en) nxt = HUNT;
      end
      HUNT: begin
        fifo_pop = hunt_pop;
        if (lock_ok) begin
          nxt = ALIGNED;
        end else if (tmo_cnt == TMO_LAST) begin
          nxt = ERR;
        end
      end
      ALIGNED: begin
        pop_all  = all_rdy;
        fifo_pop = {NUM_CHANNELS{all_rdy}};
`ifdef CA_RX_ALIGN_MARKER_CHECK_EN
        if (all_rdy && mk_mismatch) nxt = ERR;
`endif
      end
      ERR: begin
        nxt = ERR;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
    if (!align_en) begin
      nxt      = IDLE;
      fifo_pop = '0;
      pop_all  = 1'b0;
    end
  end

  // Hunt timeout and discard counters; zeroed whenever idle or heading to idle.
  always_ff @(posedge com_clk) begin
    if (rst_com) begin
      tmo_cnt  <= '0;
      skip_cnt <= '0;
    end else if (st == IDLE || nxt == IDLE) begin
      tmo_cnt  <= '0;
      skip_cnt <= '0;
    end else if (st == HUNT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
      if (|fifo_pop) skip_cnt <= skip_sat_inc(skip_cnt);
    end
  end

  // Sticky error: set on entry to ERR, cleared only on entry to IDLE.
  always_ff @(posedge com_clk) begin
    if (rst_com) begin
      align_err <= 1'b0;
    end else if (nxt == IDLE) begin
      align_err <= 1'b0;
    end else if (nxt == ERR) begin
      align_err <= 1'b1;
    end
  end

  // Aligned output register: captures the heads on each lockstep pop, holds otherwise.
  always_ff @(posedge com_clk) begin
    if (rst_com) begin
      rx_data     <= '0;
      rx_data_vld <= 1'b0;
    end else begin
      rx_data_vld <= pop_all;
      if (pop_all) rx_data <= head_dat;
    end
  end

  // Lock indication straight from the state register.
  always_comb begin
    align_done = (st == ALIGNED);
  end

endmodule

// File: tb/tb_ca_rx_align_ctrl.sv
// Directed bench for ca_rx_align_ctrl: two-channel instance fed from queue-backed FIFOs plus a single-channel instance.
// Latency: checks pop same cycle, data one cycle later.
// Backpressure: exercised by holding a channel empty while aligned.
module tb_ca_rx_align_ctrl;

  localparam int NC = 2;
  localparam int BW = 80;
  localparam int ML = 76;
  localparam int TW = 4;
  localparam int DW = NC * BW;

  logic          com_clk = 1'b0;
  logic          rst_com;
  logic          align_en;
  logic [NC-1:0] rd_empty;
  logic [DW-1:0] rx_dout;
  logic [NC-1:0] fifo_pop;
  logic [DW-1:0] rx_data;
  logic          rx_data_vld;
  logic          align_done;
  logic          align_err;
  logic [7:0]    skip_cnt;

  logic          en1;
  logic [0:0]    empty1;
  logic [BW-1:0] dout1;
  logic [0:0]    pop1;
  logic [BW-1:0] data1;
  logic          vld1;
  logic          done1;
  logic          err1;
  logic [7:0]    skip1;

  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  logic [NC-1:0] hold;
  int            n_chk = 0;
  int            n_err = 0;

  always #5 com_clk = ~com_clk;

  ca_rx_align_ctrl #(
    .NUM_CHANNELS (NC), .BITS_PER_CHANNEL (BW), .MARKER_LOC (ML), .TIMEOUT_W (TW)
  ) u_dut (
    .com_clk (com_clk), .rst_com (rst_com), .align_en (align_en), .rd_empty (rd_empty),
    .rx_dout (rx_dout), .fifo_pop (fifo_pop), .rx_data (rx_data), .rx_data_vld (rx_data_vld),
    .align_done (align_done), .align_err (align_err), .skip_cnt (skip_cnt)
  );

  ca_rx_align_ctrl #(
    .NUM_CHANNELS (1), .BITS_PER_CHANNEL (BW), .MARKER_LOC (ML), .TIMEOUT_W (TW)
  ) u_dut1 (
    .com_clk (com_clk), .rst_com (rst_com), .align_en (en1), .rd_empty (empty1),
    .rx_dout (dout1), .fifo_pop (pop1), .rx_data (data1), .rx_data_vld (vld1),
    .align_done (done1), .align_err (err1), .skip_cnt (skip1)
  );

  function automatic logic [BW-1:0] w(input logic m, input logic [15:0] tag);
    logic [BW-1:0] r;
    r        = '0;
    r[15:0]  = tag;
    r[79:64] = ~tag;
    r[ML]    = m;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    rd_empty[0]   = (q0.size() == 0) || hold[0];
    rd_empty[1]   = (q1.size() == 0) || hold[1];
    rx_dout[79:0]   = (q0.size() != 0) ? q0[0] : '0;
    rx_dout[159:80] = (q1.size() != 0) ? q1[0] : '0;
    #1;
  endtask

  task automatic tick();
    logic [NC-1:0] p;
    p = fifo_pop;
    @(posedge com_clk);
    #1;
    if (p[0] && q0.size() != 0) q0.delete(0);
    if (p[1] && q1.size() != 0) q1.delete(0);
    drive();
  endtask

  initial begin
    rst_com  = 1'b1;
    align_en = 1'b0;
    hold     = '0;
    en1      = 1'b0;
    empty1   = 1'b1;
    dout1    = '0;
    drive();
    tick();
    tick();
    chk("rst_pop", DW'(fifo_pop), DW'(0));
    chk("rst_data", rx_data, '0);
    chk("rst_vld", DW'(rx_data_vld), DW'(0));
    chk("rst_done", DW'(align_done), DW'(0));
    chk("rst_err", DW'(align_err), DW'(0));
    chk("rst_skip", DW'(skip_cnt), DW'(0));
    chk("rst1_vld", DW'(vld1), DW'(0));
    rst_com = 1'b0;

    // ch0 marker at word 0, ch1 marker at word 3; later words set up relock and mismatch cases.
    q0 = {w(1, 16'h100), w(0, 16'h101), w(1, 16'h102), w(1, 16'h103), w(0, 16'h104)};
    q1 = {w(0, 16'h200), w(0, 16'h201), w(0, 16'h202), w(1, 16'h203), w(0, 16'h204),
          w(0, 16'h205), w(1, 16'h206), w(0, 16'h207), w(0, 16'h208)};
    drive();
    chk("idle_pop", DW'(fifo_pop), DW'(0));
    align_en = 1'b1;
    #1;
    chk("idle_pop_en", DW'(fifo_pop), DW'(0));
    tick();
    chk("hunt_pop1", DW'(fifo_pop), DW'(2'b10));
    chk("hunt_done", DW'(align_done), DW'(0));
    tick();
    chk("hunt_skip1", DW'(skip_cnt), DW'(1));
    chk("hunt_pop2", DW'(fifo_pop), DW'(2'b10));
    tick();
    chk("hunt_skip2", DW'(skip_cnt), DW'(2));
    tick();
    chk("hunt_skip3", DW'(skip_cnt), DW'(3));
    chk("lock_nopop", DW'(fifo_pop), DW'(0));
    tick();
    chk("aligned_done", DW'(align_done), DW'(1));
    chk("aligned_pop", DW'(fifo_pop), DW'(2'b11));
    chk("aligned_skip", DW'(skip_cnt), DW'(3));
    tick();
    chk("first_vld", DW'(rx_data_vld), DW'(1));
    chk("first_data", rx_data, {w(1, 16'h203), w(1, 16'h100)});

    // ch1 empty for two cycles while aligned.
    hold = 2'b10;
    drive();
    chk("stall_pop0", DW'(fifo_pop), DW'(0));
    tick();
    chk("stall_vld0", DW'(rx_data_vld), DW'(0));
    chk("stall_hold", rx_data, {w(1, 16'h203), w(1, 16'h100)});
    chk("stall_pop1", DW'(fifo_pop), DW'(0));
    tick();
    chk("stall_vld1", DW'(rx_data_vld), DW'(0));
    hold = 2'b00;
    drive();
    chk("resume_pop", DW'(fifo_pop), DW'(2'b11));
    tick();
    chk("resume_vld", DW'(rx_data_vld), DW'(1));
    chk("resume_data", rx_data, {w(0, 16'h204), w(0, 16'h101)});

    // align_en dropped while aligned and both FIFOs non-empty.
    chk("pre_drop_pop", DW'(fifo_pop), DW'(2'b11));
    align_en = 1'b0;
    #1;
    chk("drop_pop", DW'(fifo_pop), DW'(0));
    tick();
    chk("drop_done", DW'(align_done), DW'(0));
    chk("drop_vld", DW'(rx_data_vld), DW'(0));
    tick();
    chk("idle_skip", DW'(skip_cnt), DW'(0));
    chk("idle_err", DW'(align_err), DW'(0));

    // Relock on 0x102/0x206, then ch0 presents a marker while ch1 does not.
    align_en = 1'b1;
    #1;
    tick();
    chk("relock_pop", DW'(fifo_pop), DW'(2'b10));
    tick();
    chk("relock_skip", DW'(skip_cnt), DW'(1));
    chk("relock_nopop", DW'(fifo_pop), DW'(0));
    tick();
    chk("relock_done", DW'(align_done), DW'(1));
    chk("relock_pop2", DW'(fifo_pop), DW'(2'b11));
    tick();
    chk("relock_vld", DW'(rx_data_vld), DW'(1));
    chk("relock_data", rx_data, {w(1, 16'h206), w(1, 16'h102)});
    chk("mm_pop", DW'(fifo_pop), DW'(2'b11));
    tick();
    chk("mm_vld", DW'(rx_data_vld), DW'(1));
    chk("mm_data", rx_data, {w(0, 16'h207), w(1, 16'h103)});
`ifdef CA_RX_ALIGN_MARKER_CHECK_EN
    chk("mm_done", DW'(align_done), DW'(0));
    chk("mm_err", DW'(align_err), DW'(1));
    chk("mm_err_pop", DW'(fifo_pop), DW'(0));
    tick();
    chk("mm_err_vld", DW'(rx_data_vld), DW'(0));
    chk("mm_err_sticky", DW'(align_err), DW'(1));
`else
    chk("mm_done", DW'(align_done), DW'(1));
    chk("mm_err", DW'(align_err), DW'(0));
    chk("mm_pop", DW'(fifo_pop), DW'(2'b11));
`endif
    align_en = 1'b0;
    #1;
    tick();
    chk("mm_idle_err", DW'(align_err), DW'(0));
    chk("mm_idle_done", DW'(align_done), DW'(0));

    // Hunt timeout: no marker ever shows up.
    q0.delete();
    q1.delete();
    for (int i = 0; i < 20; i++) begin
      q0.push_back(w(0, 16'h300 + 16'(i)));
      q1.push_back(w(0, 16'h400 + 16'(i)));
    end
    drive();
    align_en = 1'b1;
    #1;
    tick();
    for (int i = 0; i < 14; i++) tick();
    chk("tmo_pre_err", DW'(align_err), DW'(0));
    chk("tmo_pre_pop", DW'(fifo_pop), DW'(2'b11));
    chk("tmo_pre_skip", DW'(skip_cnt), DW'(14));
    tick();
    chk("tmo_err", DW'(align_err), DW'(1));
    chk("tmo_pop", DW'(fifo_pop), DW'(0));
    chk("tmo_skip", DW'(skip_cnt), DW'(15));
    chk("tmo_done", DW'(align_done), DW'(0));
    tick();
    chk("tmo_skip_hold", DW'(skip_cnt), DW'(15));
    chk("tmo_vld", DW'(rx_data_vld), DW'(0));
    align_en = 1'b0;
    #1;
    tick();
    chk("tmo_clear", DW'(align_err), DW'(0));

    // Reset pulsed mid-hunt with skip_cnt at 5.
    q0.delete();
    q1.delete();
    q0.push_back(w(1, 16'h500));
    for (int i = 0; i < 8; i++) q1.push_back(w(0, 16'h600 + 16'(i)));
    drive();
    align_en = 1'b1;
    #1;
    tick();
    repeat (5) tick();
    chk("rst_pre_skip", DW'(skip_cnt), DW'(5));
    rst_com = 1'b1;
    tick();
    chk("midrst_skip", DW'(skip_cnt), DW'(0));
    chk("midrst_pop", DW'(fifo_pop), DW'(0));
    chk("midrst_vld", DW'(rx_data_vld), DW'(0));
    chk("midrst_data", rx_data, '0);
    chk("midrst_done", DW'(align_done), DW'(0));
    chk("midrst_err", DW'(align_err), DW'(0));
    rst_com  = 1'b0;
    align_en = 1'b0;

    // Single channel locks on its first marker.
    dout1  = w(0, 16'h700);
    empty1 = 1'b0;
    en1    = 1'b1;
    #1;
    chk("one_idle_pop", DW'(pop1), DW'(0));
    tick();
    chk("one_hunt_pop", DW'(pop1), DW'(1));
    tick();
    dout1 = w(1, 16'h701);
    #1;
    chk("one_skip", DW'(skip1), DW'(1));
    chk("one_hold", DW'(pop1), DW'(0));
    tick();
    chk("one_done", DW'(done1), DW'(1));
    chk("one_pop", DW'(pop1), DW'(1));
    tick();
    chk("one_vld", DW'(vld1), DW'(1));
    chk("one_data", DW'(data1), DW'(w(1, 16'h701)));
    chk("one_err", DW'(err1), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ca_rx_align_ctrl.md
# ca_rx_align_ctrl

Channel-alignment controller sitting directly downstream of the per-channel RX alignment FIFOs, in the com_clk domain. It hunts for the alignment marker bit at the head of every channel FIFO and discards pre-marker words per channel to remove inter-channel skew. Once all heads carry the marker, it pops all FIFOs in lockstep and presents one aligned, registered wide word per cycle to the adapter. It also flags hunt timeouts and marker misalignment after lock.

## Interface
Parameters:
- NUM_CHANNELS, 2, number of aligned channels (1..24)
- BITS_PER_CHANNEL, 80, word width per channel
- MARKER_LOC, 76, bit index of the alignment marker within a channel word
- TIMEOUT_W, 8, hunt-timeout counter width; timeout after 2^TIMEOUT_W-1 hunt cycles

Ports:
- com_clk  in  1  core clock
- rst_com  in  1  reset; one clock; reset is synchronous and active-high
- align_en  in  1  enable; low forces IDLE
- rd_empty  in  NUM_CHANNELS  per-channel FIFO empty
- rx_dout  in  NUM_CHANNELS*BITS_PER_CHANNEL  per-channel FIFO head data (show-ahead); channel n at [n*BITS_PER_CHANNEL +: BITS_PER_CHANNEL]
- fifo_pop  out  NUM_CHANNELS  per-channel pop, combinational
- rx_data  out  NUM_CHANNELS*BITS_PER_CHANNEL  aligned output word, registered
- rx_data_vld  out  1  rx_data valid, registered
- align_done  out  1  in ALIGNED state
- align_err  out  1  sticky error: timeout or marker mismatch
- skip_cnt  out  8  saturating count of words discarded during hunt

## Operation
- mk[n] = rx_dout[n*BITS_PER_CHANNEL+MARKER_LOC].
- all_rdy = no rd_empty bit set.
- States: IDLE, HUNT, ALIGNED, ERR.
- IDLE:
  - fifo_pop=0; timeout and skip_cnt cleared.
  - align_en=1 -> HUNT.
- HUNT:
  - Per channel n: fifo_pop[n] = !rd_empty[n] && !mk[n]. Discard; skip_cnt += 1 per discarding cycle, not per channel; saturates at 255.
  - A channel with mk[n]=1 holds its head.
  - all_rdy && all mk=1 -> ALIGNED; no pop that cycle.
  - Timeout counter increments each HUNT cycle. Reaching 2^TIMEOUT_W-1 -> ERR.
- ALIGNED:
  - fifo_pop = {NUM_CHANNELS{all_rdy}}: all or none, never partial.
  - On each pop, rx_data <= rx_dout and rx_data_vld <= 1; otherwise rx_data_vld <= 0 and rx_data holds.
- ERR:
  - fifo_pop=0; align_err=1; rx_data_vld=0.
  - Leaves only via align_en=0 -> IDLE.
- align_en=0 in any state -> IDLE next cycle. fifo_pop gated by align_en the same cycle.
- align_done=1 exactly while in ALIGNED.
- align_err cleared only by reset or entry to IDLE.

## Timing
- Reset values: state IDLE; fifo_pop=0, rx_data=0, rx_data_vld=0, align_done=0, align_err=0, skip_cnt=0.
- fifo_pop is combinational from registered state plus the rd_empty/rx_dout inputs. No registered path between pop and FIFO.
- Pop-to-data latency: rx_data_vld is high the cycle after fifo_pop.
- HUNT->ALIGNED takes 1 cycle after the marker condition is seen. First aligned pop is in the first ALIGNED cycle.
- Single-channel boundary: NUM_CHANNELS=1 locks on the first marker.
- Reset mid-operation: rst_com wins over align_en. All outputs return to reset values on the next edge.

## Configuration
- CA_RX_ALIGN_MARKER_CHECK_EN defined:
  - In ALIGNED, on each pop, mk[n] must equal mk[0] for all n.
  - Any mismatch -> ERR next cycle; the mismatching word is still delivered with rx_data_vld=1.
- Not defined: no post-lock marker checking; ALIGNED is left only via align_en=0 or reset.

## Structure
- Package ca_rx_align_pkg holds:
  - typedef enum logic [1:0] {IDLE, HUNT, ALIGNED, ERR} ca_align_st_t
  - SKIP_CNT_W = 8
- Sub-module ca_rx_align_lane, one instance per channel in a generate loop:
  - Extracts mk[n].
  - Computes the hunt pop and the lane-ready condition.
- Top level holds the FSM, counters and output register.

## Test plan
- NUM_CHANNELS=2; ch0 marker at word 0, ch1 marker at word 3; align_en=1 -> ch1 pops 3 words, ch0 holds; ALIGNED after last discard; skip_cnt=3; first rx_data = both marker words.
- ALIGNED with ch1 empty for 2 cycles -> fifo_pop=2'b00 and rx_data_vld=0 for those cycles; resumes with no partial pops.
- TIMEOUT_W=4, no marker ever presented -> ERR after 15 HUNT cycles; align_err=1; pops stop; align_en=0 -> IDLE and align_err=0.
- With CA_RX_ALIGN_MARKER_CHECK_EN, inject a word with mk0=1, mk1=0 in ALIGNED -> word delivered, then ERR next cycle; align_done=0.
- align_en dropped mid-ALIGNED while FIFOs non-empty -> fifo_pop=0 the same cycle; IDLE next cycle; rx_data_vld=0.
- rst_com pulsed during HUNT with skip_cnt=5 -> all outputs at reset values next cycle; skip_cnt=0.
